// File: rtl/mvu_pkg.sv
// Shared widths, product-mode encoding and control-pipeline records for the
// matrix-vector unit.
package mvu_pkg;
    localparam int N         = 64;
    localparam int BWBANKA   = 9;
    localparam int BWBANKW   = N * N;
    localparam int BDBANKA   = 14;
    localparam int BDBANKW   = N;
    localparam int BACC      = 27;
    localparam int BSCALERB  = 16;
    localparam int QMSBLOCBD = $clog2(BACC);
    localparam int BCNT      = $clog2(N) + 1;
    localparam int BPROD     = BACC + BSCALERB;

    localparam logic signed [BACC-1:0] ACC_MIN = {1'b1, {(BACC-1){1'b0}}};

    typedef enum logic [1:0] {
        MUL_NONE = 2'b00,
        MUL_AND  = 2'b01,
        MUL_XNOR = 2'b10,
        MUL_TERN = 2'b11
    } mul_mode_e;

    // Accumulate-stage controls, aligned with the RAM outputs.
    typedef struct packed {
        mul_mode_e mul_mode;
        logic      neg_acc;
        logic      clr;
        logic      load;
        logic      sh;
        logic      accum;
    } s1_ctrl_t;

    // Scale/max-stage controls, aligned with the accumulator outputs.
    typedef struct packed {
        logic [BSCALERB-1:0] scaler_b;
        logic                max_clr;
        logic                max_en;
        logic                max_pool;
    } s2_ctrl_t;

    function automatic logic [BCNT-1:0] popcount(input logic [N-1:0] v);
        logic [BCNT-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c += BCNT'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/mvu_arb.sv
// Three-requester fixed-priority grant logic (hi > mid > lo), purely combinational.
module mvu_arb (
    input  logic hi_en,
    input  logic mid_en,
    input  logic lo_en,
    output logic hi_grnt,
    output logic mid_grnt,
    output logic lo_grnt
);
    assign hi_grnt  = hi_en;
    assign mid_grnt = mid_en & ~hi_en;
    assign lo_grnt  = lo_en & ~hi_en & ~mid_en;
endmodule

// File: rtl/mvu.sv
// Matrix-vector unit: bit-plane N x N product, per-row shift-accumulate,
// scale, max-pool and bit-serial quantizer with write-back to local data RAM.
module mvu
    import mvu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mul_mode,
    input  logic                 neg_acc,
    input  logic                 shacc_clr,
    input  logic                 shacc_load,
    input  logic                 shacc_acc,
    input  logic                 shacc_sh,
    input  logic [BSCALERB-1:0]  scaler_b,
    input  logic                 max_en,
    input  logic                 max_clr,
    input  logic                 max_pool,
    input  logic                 quant_clr,
    input  logic                 quant_step,
    input  logic                 quant_load,
    input  logic [QMSBLOCBD-1:0] quant_msbidx,
    input  logic [BWBANKA-1:0]   rdw_addr,
    input  logic [BWBANKA-1:0]   wrw_addr,
    input  logic [BWBANKW-1:0]   wrw_word,
    input  logic                 wrw_en,
    input  logic                 rdd_en,
    input  logic                 wrd_en,
    output logic                 rdd_grnt,
    output logic                 wrd_grnt,
    input  logic [BDBANKA-1:0]   rdd_addr,
    input  logic [BDBANKA-1:0]   wrd_addr,
    input  logic                 rdi_en,
    input  logic                 wri_en,
    output logic                 rdi_grnt,
    output logic                 wri_grnt,
    input  logic [BDBANKA-1:0]   rdi_addr,
    input  logic [BDBANKA-1:0]   wri_addr,
    input  logic [BDBANKW-1:0]   wri_word,
    output logic [BDBANKW-1:0]   rdi_word,
    input  logic                 rdc_en,
    input  logic                 wrc_en,
    output logic                 rdc_grnt,
    output logic                 wrc_grnt,
    input  logic [BDBANKA-1:0]   rdc_addr,
    input  logic [BDBANKA-1:0]   wrc_addr,
    input  logic [BDBANKW-1:0]   wrc_word,
    output logic [BDBANKW-1:0]   rdc_word
);
    logic [BDBANKA-1:0]   rd_addr, wr_addr;
    logic [BDBANKW-1:0]   wr_word;
    logic                 wr_any;
    logic [N-1:0]         qout;
    logic [BWBANKW-1:0]   wram [2**BWBANKA];
    logic [BDBANKW-1:0]   dram [2**BDBANKA];
    logic [BWBANKW-1:0]   w_q;
    logic [N-1:0]         d_q;
    s1_ctrl_t             s1_q;
    s2_ctrl_t             s2_d1, s2_q;
    logic [QMSBLOCBD-1:0] q_idx, q_idx_nxt;

    mvu_arb u_rd_arb (
        .hi_en(rdc_en), .mid_en(rdi_en), .lo_en(rdd_en),
        .hi_grnt(rdc_grnt), .mid_grnt(rdi_grnt), .lo_grnt(rdd_grnt)
    );

    mvu_arb u_wr_arb (
        .hi_en(wrc_en), .mid_en(wri_en), .lo_en(wrd_en),
        .hi_grnt(wrc_grnt), .mid_grnt(wri_grnt), .lo_grnt(wrd_grnt)
    );

    // NOTE: every variable gets its default first, so no path leaves it unassigned (no latch).
    always_comb begin
        rd_addr = rdd_addr;
        if (rdi_grnt) rd_addr = rdi_addr;
        if (rdc_grnt) rd_addr = rdc_addr;
        wr_addr = wrd_addr;
        wr_word = qout;
        if (wri_grnt) begin
            wr_addr = wri_addr;
            wr_word = wri_word;
        end
        if (wrc_grnt) begin
            wr_addr = wrc_addr;
            wr_word = wrc_word;
        end
    end

    assign wr_any = wrc_grnt | wri_grnt | wrd_grnt;

    // NOTE: RAM arrays are never reset; only the registers around them are.
    // NOTE: state uses <= so each register samples pre-edge values; a same-address
    // write and read in one cycle therefore returns the old word.
    always_ff @(posedge clk) begin
        if (wrw_en) wram[wrw_addr] <= wrw_word;
        if (wr_any) dram[wr_addr] <= wr_word;
        w_q <= wram[rdw_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= '0;
            rdi_word <= '0;
            rdc_word <= '0;
        end else begin
            d_q <= rdd_grnt ? dram[rd_addr] : '0;
            if (rdi_grnt) rdi_word <= dram[rd_addr];
            if (rdc_grnt) rdc_word <= dram[rd_addr];
        end
    end

    // Stage-1 controls meet the RAM outputs; stage-2 controls meet the accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_d1 <= '0;
            s2_q  <= '0;
        end else begin
            s1_q  <= '{mul_mode: mul_mode_e'(mul_mode), neg_acc: neg_acc, clr: shacc_clr,
                       load: shacc_load, sh: shacc_sh, accum: shacc_acc};
            s2_d1 <= '{scaler_b: scaler_b, max_clr: max_clr, max_en: max_en, max_pool: max_pool};
            s2_q  <= s2_d1;
        end
    end

    // Start bits beyond the accumulator MSB clamp to the MSB.
    always_comb begin
        q_idx_nxt = q_idx;
        if (quant_clr)
            q_idx_nxt = '0;
        else if (quant_load)
            q_idx_nxt = (quant_msbidx > QMSBLOCBD'(BACC - 1)) ? QMSBLOCBD'(BACC - 1) : quant_msbidx;
        else if (quant_step && q_idx != '0)
            q_idx_nxt = q_idx - QMSBLOCBD'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) q_idx <= '0;
        else     q_idx <= q_idx_nxt;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        logic [N-1:0]           w_row;
        logic signed [BACC-1:0] dot, acc, s, m, p, q_val, q_val_nxt;
        logic signed [BPROD-1:0] prod;
        logic                   qbit;

        assign w_row = w_q[r*N +: N];

        always_comb begin
            case (s1_q.mul_mode)
                MUL_AND:  dot = BACC'(popcount(w_row & d_q));
                MUL_XNOR: dot = BACC'({popcount(~(w_row ^ d_q)), 1'b0}) - BACC'(N);
                MUL_TERN: dot = BACC'(popcount(w_row & d_q)) - BACC'(popcount(~w_row & d_q));
                default:  dot = '0;
            endcase
            if (s1_q.neg_acc) dot = -dot;
        end

        always_ff @(posedge clk) begin
            if (rst)               acc <= '0;
            else if (s1_q.clr)     acc <= '0;
            else if (s1_q.load)    acc <= dot;
            else if (s1_q.sh)      acc <= (acc <<< 1) + dot;
            else if (s1_q.accum)   acc <= acc + dot;
        end

        assign prod = BPROD'(acc) * BPROD'($signed(s2_q.scaler_b));
        assign s    = (s2_q.scaler_b == '0) ? acc : prod[BACC-1:0];

        always_ff @(posedge clk) begin
            if (rst) begin
                m <= ACC_MIN;
                p <= '0;
            end else begin
                if (s2_q.max_clr)                m <= ACC_MIN;
                else if (s2_q.max_en && s > m)   m <= s;
                p <= (s2_q.max_pool && m > s) ? m : s;
            end
        end

        always_comb begin
            q_val_nxt = q_val;
            if (quant_clr)       q_val_nxt = '0;
            else if (quant_load) q_val_nxt = p;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q_val <= '0;
                qbit  <= 1'b0;
            end else begin
                q_val <= q_val_nxt;
                qbit  <= q_val_nxt[q_idx_nxt];
            end
        end

        assign qout[r] = qbit;
    end
endmodule

// File: tb/tb_mvu.sv
// Directed bench for mvu: arbitration, RAM ports, product modes, accumulate
// wrap, scaler, max-pool and bit-serial quantizer with write-back.
module tb_mvu;
    import mvu_pkg::*;

    localparam logic [3:0] C_NONE = 4'b0000, C_CLR = 4'b1000, C_LOAD = 4'b0100,
                           C_SH = 4'b0010, C_ACC = 4'b0001;
    localparam logic [2:0] M_NONE = 3'b000, M_CLR = 3'b100, M_EN = 3'b010, M_POOL = 3'b001;
    localparam logic [BDBANKA-1:0] D_ONES = 14'd0, D_ZERO = 14'd1, D_5 = 14'd2, D_3 = 14'd3,
                                   D_9 = 14'd4, D_2 = 14'd5, D_11 = 14'd6;
    localparam logic [BWBANKA-1:0] W_ONES = 9'd0, W_TRI = 9'd1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [1:0]           mul_mode = '0;
    logic                 neg_acc = 1'b0;
    logic                 shacc_clr = 1'b0, shacc_load = 1'b0, shacc_acc = 1'b0, shacc_sh = 1'b0;
    logic [BSCALERB-1:0]  scaler_b = '0;
    logic                 max_en = 1'b0, max_clr = 1'b0, max_pool = 1'b0;
    logic                 quant_clr = 1'b0, quant_step = 1'b0, quant_load = 1'b0;
    logic [QMSBLOCBD-1:0] quant_msbidx = '0;
    logic [BWBANKA-1:0]   rdw_addr = '0, wrw_addr = '0;
    logic [BWBANKW-1:0]   wrw_word = '0;
    logic                 wrw_en = 1'b0;
    logic                 rdd_en = 1'b0, wrd_en = 1'b0, rdd_grnt, wrd_grnt;
    logic [BDBANKA-1:0]   rdd_addr = '0, wrd_addr = '0;
    logic                 rdi_en = 1'b0, wri_en = 1'b0, rdi_grnt, wri_grnt;
    logic [BDBANKA-1:0]   rdi_addr = '0, wri_addr = '0;
    logic [BDBANKW-1:0]   wri_word = '0, rdi_word;
    logic                 rdc_en = 1'b0, wrc_en = 1'b0, rdc_grnt, wrc_grnt;
    logic [BDBANKA-1:0]   rdc_addr = '0, wrc_addr = '0;
    logic [BDBANKW-1:0]   wrc_word = '0, rdc_word;

    logic [BWBANKW-1:0]   tri_w;
    int                   n_checks = 0;
    int                   n_fail = 0;

    always #5 clk = ~clk;

    mvu dut (
        .clk(clk), .rst(rst), .mul_mode(mul_mode), .neg_acc(neg_acc),
        .shacc_clr(shacc_clr), .shacc_load(shacc_load), .shacc_acc(shacc_acc), .shacc_sh(shacc_sh),
        .scaler_b(scaler_b), .max_en(max_en), .max_clr(max_clr), .max_pool(max_pool),
        .quant_clr(quant_clr), .quant_step(quant_step), .quant_load(quant_load),
        .quant_msbidx(quant_msbidx), .rdw_addr(rdw_addr), .wrw_addr(wrw_addr),
        .wrw_word(wrw_word), .wrw_en(wrw_en), .rdd_en(rdd_en), .wrd_en(wrd_en),
        .rdd_grnt(rdd_grnt), .wrd_grnt(wrd_grnt), .rdd_addr(rdd_addr), .wrd_addr(wrd_addr),
        .rdi_en(rdi_en), .wri_en(wri_en), .rdi_grnt(rdi_grnt), .wri_grnt(wri_grnt),
        .rdi_addr(rdi_addr), .wri_addr(wri_addr), .wri_word(wri_word), .rdi_word(rdi_word),
        .rdc_en(rdc_en), .wrc_en(wrc_en), .rdc_grnt(rdc_grnt), .wrc_grnt(wrc_grnt),
        .rdc_addr(rdc_addr), .wrc_addr(wrc_addr), .wrc_word(wrc_word), .rdc_word(rdc_word)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_c(input logic [BDBANKA-1:0] a, input logic [BDBANKW-1:0] w);
        wrc_en = 1'b1; wrc_addr = a; wrc_word = w;
        tick();
        wrc_en = 1'b0;
    endtask

    task automatic rd_c(input logic [BDBANKA-1:0] a);
        rdc_en = 1'b1; rdc_addr = a;
        tick();
        rdc_en = 1'b0;
    endtask

    task automatic wr_w(input logic [BWBANKA-1:0] a, input logic [BWBANKW-1:0] w);
        wrw_en = 1'b1; wrw_addr = a; wrw_word = w;
        tick();
        wrw_en = 1'b0;
    endtask

    // One compute instruction held for one cycle; acc is visible one tick after return, m/p two.
    task automatic op(input logic [1:0] mode, input logic neg, input logic [3:0] ctl,
                      input logic [BDBANKA-1:0] da, input logic [BWBANKA-1:0] wa,
                      input logic [2:0] mx, input logic [BSCALERB-1:0] scl);
        mul_mode = mode; neg_acc = neg;
        {shacc_clr, shacc_load, shacc_sh, shacc_acc} = ctl;
        {max_clr, max_en, max_pool} = mx;
        scaler_b = scl; rdd_en = 1'b1; rdd_addr = da; rdw_addr = wa;
        tick();
        mul_mode = 2'b00; neg_acc = 1'b0;
        {shacc_clr, shacc_load, shacc_sh, shacc_acc} = 4'b0000;
        {max_clr, max_en, max_pool} = 3'b000;
        scaler_b = '0; rdd_en = 1'b0;
    endtask

    task automatic qctl(input logic clr, input logic load, input logic step);
        quant_clr = clr; quant_load = load; quant_step = step;
        tick();
        {quant_clr, quant_load, quant_step} = 3'b000;
    endtask

    initial begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tri_w[r*N + c] = (c < r);

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_acc", 64'(dut.g_row[0].acc), 64'd0);
        check("reset_m", 64'(dut.g_row[63].m), 64'(-67108864));
        check("reset_qout", dut.qout, 64'd0);
        check("reset_rdc_word", rdc_word, 64'd0);
        check("reset_rdi_word", rdi_word, 64'd0);

        rdc_en = 1'b1; rdi_en = 1'b1; rdd_en = 1'b1; #1;
        check("rd_grant_all", 64'({rdc_grnt, rdi_grnt, rdd_grnt}), 64'h4);
        rdc_en = 1'b0; #1;
        check("rd_grant_i_d", 64'({rdc_grnt, rdi_grnt, rdd_grnt}), 64'h2);
        rdi_en = 1'b0; #1;
        check("rd_grant_d", 64'({rdc_grnt, rdi_grnt, rdd_grnt}), 64'h1);
        rdd_en = 1'b0;
        wrc_en = 1'b1; wri_en = 1'b1; wrd_en = 1'b1; #1;
        check("wr_grant_all", 64'({wrc_grnt, wri_grnt, wrd_grnt}), 64'h4);
        wrc_en = 1'b0; wri_en = 1'b0; wrd_en = 1'b0;
        tick();

        wr_w(W_ONES, {BWBANKW{1'b1}});
        wr_w(W_TRI, tri_w);
        wr_c(D_ONES, {BDBANKW{1'b1}});
        wr_c(D_ZERO, 64'h0);
        wr_c(D_5, 64'h1F);
        wr_c(D_3, 64'h7);
        wr_c(D_9, 64'h1FF);
        wr_c(D_2, 64'h3);
        wr_c(D_11, 64'h7FF);

        rd_c(D_ONES);
        check("rdc_read", rdc_word, {BDBANKW{1'b1}});
        rdi_en = 1'b1; rdi_addr = D_5;
        tick();
        rdi_en = 1'b0;
        check("rdi_read", rdi_word, 64'h1F);
        rdc_en = 1'b1; rdc_addr = D_9; rdi_en = 1'b1; rdi_addr = D_11; rdd_en = 1'b1;
        tick();
        rdc_en = 1'b0; rdi_en = 1'b0; rdd_en = 1'b0;
        check("rd_prio_rdc", rdc_word, 64'h1FF);
        check("rd_prio_rdi_held", rdi_word, 64'h1F);

        wr_c(14'd11, 64'hDEAD);
        wr_c(14'd12, 64'hBEEF);
        wrc_en = 1'b1; wrc_addr = 14'd10; wrc_word = 64'h1234;
        wri_en = 1'b1; wri_addr = 14'd11; wri_word = 64'h5555;
        wrd_en = 1'b1; wrd_addr = 14'd12;
        tick();
        wrc_en = 1'b0; wri_en = 1'b0; wrd_en = 1'b0;
        rd_c(14'd10); check("wr_prio_wrc", rdc_word, 64'h1234);
        rd_c(14'd11); check("wr_prio_wri_dropped", rdc_word, 64'hDEAD);
        rd_c(14'd12); check("wr_prio_wrd_dropped", rdc_word, 64'hBEEF);

        wr_c(14'd20, 64'h1111);
        wrc_en = 1'b1; wrc_addr = 14'd20; wrc_word = 64'h2222;
        rdc_en = 1'b1; rdc_addr = 14'd20;
        tick();
        wrc_en = 1'b0; rdc_en = 1'b0;
        check("collision_read_old", rdc_word, 64'h1111);
        rd_c(14'd20); check("collision_read_new", rdc_word, 64'h2222);

        op(MUL_AND, 1'b0, C_LOAD, D_ONES, W_ONES, M_NONE, 16'h0); tick();
        check("and_load_row0", 64'(dut.g_row[0].acc), 64'd64);
        check("and_load_row63", 64'(dut.g_row[63].acc), 64'd64);
        op(MUL_XNOR, 1'b0, C_LOAD, D_ZERO, W_ONES, M_NONE, 16'h0); tick();
        check("xnor_load", 64'(dut.g_row[17].acc), 64'(-64));
        op(MUL_XNOR, 1'b1, C_ACC, D_ZERO, W_ONES, M_NONE, 16'h0); tick();
        check("xnor_neg_acc", 64'(dut.g_row[17].acc), 64'd0);

        op(MUL_AND, 1'b0, C_LOAD, D_ONES, W_ONES, M_NONE, 16'h0);
        op(MUL_AND, 1'b0, C_SH, D_ONES, W_ONES, M_NONE, 16'h0); tick();
        check("bit_serial_3x", 64'(dut.g_row[40].acc), 64'd192);

        op(MUL_AND, 1'b0, C_LOAD, D_ONES, W_TRI, M_NONE, 16'h0); tick();
        check("tri_and_row0", 64'(dut.g_row[0].acc), 64'd0);
        check("tri_and_row31", 64'(dut.g_row[31].acc), 64'd31);
        check("tri_and_row63", 64'(dut.g_row[63].acc), 64'd63);
        op(MUL_XNOR, 1'b0, C_LOAD, D_ONES, W_TRI, M_NONE, 16'h0); tick();
        check("tri_xnor_row31", 64'(dut.g_row[31].acc), 64'(-2));
        check("tri_xnor_row63", 64'(dut.g_row[63].acc), 64'd62);
        op(MUL_TERN, 1'b0, C_LOAD, D_5, W_TRI, M_NONE, 16'h0); tick();
        check("tern_row0", 64'(dut.g_row[0].acc), 64'(-5));
        check("tern_row3", 64'(dut.g_row[3].acc), 64'd1);
        check("tern_row63", 64'(dut.g_row[63].acc), 64'd5);

        op(MUL_AND, 1'b0, C_LOAD, D_ONES, W_ONES, M_NONE, 16'h0);
        for (int i = 0; i < 20; i++) op(MUL_NONE, 1'b0, C_SH, D_ONES, W_ONES, M_NONE, 16'h0);
        tick();
        check("wrap_to_min", 64'(dut.g_row[5].acc), 64'(-67108864));
        op(MUL_AND, 1'b0, C_ACC, D_ONES, W_ONES, M_NONE, 16'h0); tick();
        check("acc_near_min", 64'(dut.g_row[5].acc), 64'(-67108800));
        op(MUL_NONE, 1'b0, C_SH, D_ONES, W_ONES, M_NONE, 16'h0); tick();
        check("shift_wrap", 64'(dut.g_row[5].acc), 64'd128);
        op(MUL_AND, 1'b0, C_LOAD | C_SH | C_ACC, D_5, W_ONES, M_NONE, 16'h0); tick();
        check("load_over_sh_acc", 64'(dut.g_row[5].acc), 64'd5);
        op(MUL_AND, 1'b0, C_CLR | C_LOAD, D_ONES, W_ONES, M_NONE, 16'h0); tick();
        check("clr_over_load", 64'(dut.g_row[5].acc), 64'd0);

        op(MUL_AND, 1'b0, C_LOAD, D_5, W_ONES, M_NONE, 16'hFFFD); tick(); tick();
        check("scaler_neg3", 64'(dut.g_row[9].p), 64'(-15));
        tick();
        check("scaler_bypass", 64'(dut.g_row[9].p), 64'd5);

        op(MUL_NONE, 1'b0, C_NONE, D_ONES, W_ONES, M_CLR, 16'h0);
        op(MUL_AND, 1'b0, C_LOAD, D_5, W_ONES, M_EN, 16'h0);
        op(MUL_AND, 1'b1, C_LOAD, D_3, W_ONES, M_EN, 16'h0);
        op(MUL_AND, 1'b0, C_LOAD, D_9, W_ONES, M_EN, 16'h0);
        op(MUL_AND, 1'b0, C_LOAD, D_2, W_ONES, M_EN | M_POOL, 16'h0);
        tick(); tick();
        check("max_m", 64'(dut.g_row[0].m), 64'd9);
        check("max_pool_p", 64'(dut.g_row[63].p), 64'd9);
        tick();
        check("no_pool_p", 64'(dut.g_row[63].p), 64'd2);
        op(MUL_NONE, 1'b0, C_NONE, D_ONES, W_ONES, M_CLR, 16'h0); tick(); tick();
        check("max_clr", 64'(dut.g_row[0].m), 64'(-67108864));

        op(MUL_AND, 1'b0, C_LOAD, D_11, W_ONES, M_NONE, 16'h0); tick(); tick();
        check("quant_src_p", 64'(dut.g_row[0].p), 64'd11);
        quant_msbidx = 5'd3;
        qctl(1'b0, 1'b1, 1'b0);
        check("quant_bit3", dut.qout, {N{1'b1}});
        wrd_en = 1'b1; wrd_addr = 14'd30;
        tick();
        wrd_en = 1'b0;
        rd_c(14'd30); check("quant_writeback", rdc_word, {N{1'b1}});
        qctl(1'b0, 1'b0, 1'b1); check("quant_bit2", dut.qout, 64'd0);
        qctl(1'b0, 1'b0, 1'b1); check("quant_bit1", dut.qout, {N{1'b1}});
        qctl(1'b0, 1'b0, 1'b1); check("quant_bit0", dut.qout, {N{1'b1}});
        qctl(1'b0, 1'b0, 1'b1); check("quant_saturate", dut.qout, {N{1'b1}});
        qctl(1'b1, 1'b0, 1'b0); check("quant_clr", dut.qout, 64'd0);

        qctl(1'b0, 1'b1, 1'b0);
        qctl(1'b0, 1'b0, 1'b1);
        qctl(1'b0, 1'b0, 1'b1);
        check("quant_reload_bit1", dut.qout, {N{1'b1}});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst_qout", dut.qout, 64'd0);
        check("midrun_rst_acc", 64'(dut.g_row[0].acc), 64'd0);
        check("midrun_rst_m", 64'(dut.g_row[0].m), 64'(-67108864));
        check("midrun_rst_rdc_word", rdc_word, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
